// File: rtl/iob_ram_rmw_ctrl.sv
// ============================================================================
// iob_ram_rmw_ctrl : IOb request controller for a TDP RAM, partial writes via 2-cycle RMW. Rev 1.0
// ============================================================================
`default_nettype none

module iob_ram_rmw_ctrl #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   input  logic [ADDR_W-1:0]   addr_i,
   input  logic [DATA_W-1:0]   wdata_i,
   input  logic [DATA_W/8-1:0] wstrb_i,
   output logic                ready_o,
   output logic [DATA_W-1:0]   rdata_o,
   output logic                rvalid_o,
   output logic                mem_en0_o,
   output logic                mem_we0_o,
   output logic [ADDR_W-1:0]   mem_addr0_o,
   output logic [DATA_W-1:0]   mem_din0_o,
   output logic                mem_en1_o,
   output logic [ADDR_W-1:0]   mem_addr1_o,
   input  logic [DATA_W-1:0]   mem_dout1_i
);

   localparam int STRB_W = DATA_W / 8;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      MERGE = 1'b1
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [STRB_W-1:0]   wstrb_q;
   logic                rvalid_q;

   logic                w_accept;
   logic                w_read;
   logic                w_full;
   logic [DATA_W-1:0]   w_merge;

   // Reset gates ready so no request can be accepted while rst is high.
   assign ready_o  = (state_q == IDLE) && !rst;
   assign w_accept = valid_i && ready_o;
   assign w_read   = (wstrb_i == '0);
   assign w_full   = &wstrb_i;
   assign rdata_o  = mem_dout1_i;
   assign rvalid_o = rvalid_q;

   generate
      for (genvar i = 0; i < STRB_W; i++) begin : g_lane
         assign w_merge[8*i +: 8] = wstrb_q[i] ? wdata_q[8*i +: 8] : mem_dout1_i[8*i +: 8];
      end
   endgenerate

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         rvalid_q <= w_accept && w_read;
         case (state_q)
            IDLE: begin
               if (w_accept && !w_read && !w_full) begin
                  state_q <= MERGE;
                  addr_q  <= addr_i;
                  wdata_q <= wdata_i;
                  wstrb_q <= wstrb_i;
               end
            end
            MERGE:   state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Memory strobes are combinational so reads and full writes issue in the request cycle.
   always_comb begin
      mem_en0_o   = 1'b0;
      mem_we0_o   = 1'b0;
      mem_addr0_o = '0;
      mem_din0_o  = '0;
      mem_en1_o   = 1'b0;
      mem_addr1_o = '0;
      if (!rst) begin
         if (state_q == MERGE) begin
            mem_en0_o   = 1'b1;
            mem_we0_o   = 1'b1;
            mem_addr0_o = addr_q;
            mem_din0_o  = w_merge;
         end else if (valid_i) begin
            if (w_full) begin
               mem_en0_o   = 1'b1;
               mem_we0_o   = 1'b1;
               mem_addr0_o = addr_i;
               mem_din0_o  = wdata_i;
            end else begin
               mem_en1_o   = 1'b1;
               mem_addr1_o = addr_i;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_iob_ram_rmw_ctrl.sv
// ============================================================================
// tb_iob_ram_rmw_ctrl : self-checking bench with a word-level memory reference model. Rev 1.0
// ============================================================================
`default_nettype none

module tb_iob_ram_rmw_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [8:0]  addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic [3:0]  wstrb_i = '0;
   logic        ready_o, rvalid_o;
   logic [31:0] rdata_o;
   logic        mem_en0_o, mem_we0_o, mem_en1_o;
   logic [8:0]  mem_addr0_o, mem_addr1_o;
   logic [31:0] mem_din0_o;
   logic [31:0] mem_dout1_i;

   iob_ram_rmw_ctrl #(.ADDR_W(9), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .valid_i(valid_i), .addr_i(addr_i), .wdata_i(wdata_i), .wstrb_i(wstrb_i),
      .ready_o(ready_o), .rdata_o(rdata_o), .rvalid_o(rvalid_o),
      .mem_en0_o(mem_en0_o), .mem_we0_o(mem_we0_o), .mem_addr0_o(mem_addr0_o),
      .mem_din0_o(mem_din0_o), .mem_en1_o(mem_en1_o), .mem_addr1_o(mem_addr1_o),
      .mem_dout1_i(mem_dout1_i)
   );

   always #5 clk = ~clk;

   // RAM macro model: write port A, registered read port B
   logic [31:0] ram [512];
   always @(posedge clk) begin
      if (mem_en0_o && mem_we0_o) ram[mem_addr0_o] <= mem_din0_o;
      if (mem_en1_o) mem_dout1_i <= ram[mem_addr1_o];
   end

   // Reference: memory contents as seen by the bus, plus outstanding-response bookkeeping
   logic [31:0] ref_mem [512];
   bit          exp_pend = 1'b0;
   logic [8:0]  pend_addr = '0;
   logic [31:0] pend_data = '0;
   bit          exp_rv = 1'b0;
   logic [31:0] exp_rdata = '0;

   int          n_pass = 0;
   int          n_total = 0;
   logic [31:0] obs_rdata = '0;
   logic [31:0] obs_din0 = '0;
   int          rv_count = 0;
   int          wr0_count = 0;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic cycle(input bit v, input logic [8:0] a, input logic [31:0] d,
                        input logic [3:0] s, output bit acc);
      bit          e_en0, e_en1, new_rv;
      logic [8:0]  e_a0, e_a1;
      logic [31:0] e_d0;
      valid_i = v; addr_i = a; wdata_i = d; wstrb_i = s;
      @(negedge clk);
      e_en0 = 0; e_en1 = 0; e_a0 = '0; e_a1 = '0; e_d0 = '0;
      if (exp_pend) begin
         e_en0 = 1; e_a0 = pend_addr; e_d0 = pend_data;
      end else if (v) begin
         if (s == 4'hF) begin
            e_en0 = 1; e_a0 = a; e_d0 = d;
         end else begin
            e_en1 = 1; e_a1 = a;
         end
      end
      chk("ready", {31'b0, ready_o}, {31'b0, !exp_pend});
      chk("rvalid", {31'b0, rvalid_o}, {31'b0, exp_rv});
      if (exp_rv) chk("rdata", rdata_o, exp_rdata);
      chk("mem_en0", {31'b0, mem_en0_o}, {31'b0, e_en0});
      chk("mem_we0", {31'b0, mem_we0_o}, {31'b0, e_en0});
      chk("mem_addr0", {23'b0, mem_addr0_o}, {23'b0, e_a0});
      chk("mem_din0", mem_din0_o, e_d0);
      chk("mem_en1", {31'b0, mem_en1_o}, {31'b0, e_en1});
      chk("mem_addr1", {23'b0, mem_addr1_o}, {23'b0, e_a1});
      if (rvalid_o) begin obs_rdata = rdata_o; rv_count++; end
      if (mem_en0_o && mem_we0_o) begin obs_din0 = mem_din0_o; wr0_count++; end
      acc = v && !exp_pend;
      @(posedge clk); #1;
      new_rv = acc && (s == 4'h0);
      if (new_rv) exp_rdata = ref_mem[a];
      if (exp_pend) begin
         ref_mem[pend_addr] = pend_data;
         exp_pend = 0;
      end else if (acc && s == 4'hF) begin
         ref_mem[a] = d;
      end else if (acc && s != 4'h0) begin
         exp_pend = 1; pend_addr = a; pend_data = merge(ref_mem[a], d, s);
      end
      exp_rv = new_rv;
   endtask

   task automatic send(input logic [8:0] a, input logic [31:0] d, input logic [3:0] s,
                       output int waits);
      bit acc;
      waits = 0;
      cycle(1'b1, a, d, s, acc);
      while (!acc && waits < 8) begin
         waits++;
         cycle(1'b1, a, d, s, acc);
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle();
      bit acc;
      cycle(1'b0, '0, '0, '0, acc);
   endtask

   initial begin
      int w, wr_before, rv_before;
      bit acc;
      logic [3:0] s;

      #1;
      chk("reset_ready", {31'b0, ready_o}, 32'd0);
      chk("reset_rvalid", {31'b0, rvalid_o}, 32'd0);
      chk("reset_en0", {31'b0, mem_en0_o}, 32'd0);
      chk("reset_en1", {31'b0, mem_en1_o}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Preload words used below through full writes
      for (int i = 0; i < 8; i++) send(9'(i), 32'h1000_0000 + 32'(i) * 32'h0101_0101, 4'hF, w);
      send(9'h020, 32'h11223344, 4'hF, w);
      send(9'h030, 32'hCAFEF00D, 4'hF, w);
      send(9'h1FF, 32'h00000000, 4'hF, w);

      // Full write then read
      wr_before = wr0_count;
      send(9'h010, 32'hDEADBEEF, 4'hF, w);
      send(9'h010, 32'h0, 4'h0, w);
      idle();
      chk("fullwr_read", obs_rdata, 32'hDEADBEEF);
      chk("fullwr_port0_writes", 32'(wr0_count - wr_before), 32'd1);

      // Partial write merge
      send(9'h020, 32'hAABBCCDD, 4'h5, w);
      idle();
      chk("merge_din0", obs_din0, 32'h11BB33DD);
      send(9'h020, 32'h0, 4'h0, w);
      idle();
      chk("merge_read", obs_rdata, 32'h11BB33DD);

      // Back-to-back reads
      rv_before = rv_count;
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 9'(i), 32'h0, 4'h0, acc);
         chk("b2b_accept", {31'b0, acc}, 32'd1);
      end
      idle();
      chk("b2b_rvalid_count", 32'(rv_count - rv_before), 32'd4);
      chk("b2b_last_data", obs_rdata, 32'h1303_0303);

      // Stall on partial write with a held read
      send(9'h030, 32'h12345678, 4'h6, w);
      send(9'h030, 32'h0, 4'h0, w);
      chk("stall_waits", 32'(w), 32'd1);
      idle();
      chk("stall_read", obs_rdata, 32'hCA3456_0D);

      // Boundary addresses and strobes
      send(9'h1FF, 32'h99000000, 4'h8, w);
      send(9'h1FF, 32'h0, 4'h0, w);
      idle();
      chk("top_addr_read", obs_rdata, 32'h99000000);
      send(9'h000, 32'hFFFFFFFF, 4'hF, w);
      send(9'h000, 32'h000000AB, 4'h1, w);
      send(9'h000, 32'h0, 4'h0, w);
      idle();
      chk("addr0_read", obs_rdata, 32'hFFFFFFAB);

      // Reset in the middle of a read-modify-write
      send(9'h040, 32'h55555555, 4'hF, w);
      send(9'h040, 32'hA5A5A5A5, 4'h3, w);
      valid_i = 1'b1; addr_i = 9'h040; wstrb_i = 4'h0;
      #1;
      chk("rmw_en0_before_rst", {31'b0, mem_en0_o}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_en0", {31'b0, mem_en0_o}, 32'd0);
      chk("rst_we0", {31'b0, mem_we0_o}, 32'd0);
      chk("rst_din0", mem_din0_o, 32'd0);
      chk("rst_addr0", {23'b0, mem_addr0_o}, 32'd0);
      chk("rst_en1", {31'b0, mem_en1_o}, 32'd0);
      chk("rst_ready", {31'b0, ready_o}, 32'd0);
      @(posedge clk); #1;
      chk("rst_hold_en1", {31'b0, mem_en1_o}, 32'd0);
      chk("rst_hold_rvalid", {31'b0, rvalid_o}, 32'd0);
      rst = 1'b0;
      valid_i = 1'b0;
      exp_pend = 0;
      exp_rv = 0;
      #1;
      chk("post_rst_ready", {31'b0, ready_o}, 32'd1);
      chk("post_rst_rvalid", {31'b0, rvalid_o}, 32'd0);
      send(9'h040, 32'h0, 4'h0, w);
      idle();
      chk("post_rst_read", obs_rdata, 32'h55555555);

      // Randomized traffic over a small address window to provoke hazards
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 3))
            0:       s = 4'h0;
            1:       s = 4'hF;
            default: s = 4'($urandom_range(1, 14));
         endcase
         cycle($urandom_range(0, 3) != 0, 9'($urandom_range(0, 7)), $urandom, s, acc);
      end
      for (int i = 0; i < 8; i++) cycle(1'b1, 9'(i), 32'h0, 4'h0, acc);
      idle();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
